// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// the bit-counter sizing helper.
package serial_adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One extra bit so the counter can represent WIDTH itself without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand and result handshakes of the serial adder; master drives operands,
// slave (the controller) returns sum/cout under its own valid/ready.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell, purely combinational.
// Zero latency; no flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ cin;
    assign carry_out = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sharing one full_adder cell, LSB first.
// Result valid WIDTH+1 cycles after accept; held in DONE until out_ready, in_ready only when IDLE or draining.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic fa_sum;
    logic fa_carry;
    logic in_ready;
    logic accept;
    logic last_bit;

    full_adder u_fa (a_sh_q[0], b_sh_q[0], carry_q, fa_sum, fa_carry);

    assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
    assign accept   = bus.in_valid & in_ready;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RUN;
            end
            ST_RUN: begin
                a_sh_d           = a_sh_q >> 1;
                b_sh_d           = b_sh_q >> 1;
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = fa_sum;
                carry_d          = fa_carry;
                cnt_d            = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = ST_DONE;
                    cout_d  = fa_carry;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = bus.in_valid ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept only happens in IDLE or DONE, so it never collides with a RUN update.
        if (accept) begin
            a_sh_d  = bus.a;
            b_sh_d  = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
            res_d   = '0;
            cout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.sum       = res_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized bench for serial_adder_ctrl at WIDTH 8, 2 and 1,
// with expected results computed as plain integer addition.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ncmp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) b8 ();
    serial_adder_ctrl_if #(.WIDTH(2)) b2 ();
    serial_adder_ctrl_if #(.WIDTH(1)) b1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    serial_adder_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One WIDTH=8 operation starting from IDLE; hold = cycles out_ready stays low in DONE.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input bit corrupt, input int hold);
        int         e;
        logic [7:0] s;
        logic       c;
        e = int'(av) + int'(bv) + int'(cv);
        b8.a = av; b8.b = bv; b8.cin = cv;
        b8.out_ready = (hold == 0);
        b8.in_valid = 1'b1;
        #1 chk("idle_in_ready", 64'(b8.in_ready), 64'(1));
        step();
        b8.in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("run_busy", 64'(b8.busy), 64'(1));
            chk("run_no_valid", 64'(b8.out_valid), 64'(0));
            if (corrupt) begin
                b8.a = 8'($urandom);
                b8.b = 8'($urandom);
                b8.cin = 1'($urandom);
            end
            step();
        end
        chk("lat_out_valid", 64'(b8.out_valid), 64'(1));
        chk("done_busy", 64'(b8.busy), 64'(0));
        chk("sum8", 64'(b8.sum), 64'(e & 32'hFF));
        chk("cout8", 64'(b8.cout), 64'((e >> 8) & 1));
        s = b8.sum;
        c = b8.cout;
        for (int h = 0; h < hold; h++) begin
            chk("bp_in_ready", 64'(b8.in_ready), 64'(0));
            step();
            chk("bp_valid", 64'(b8.out_valid), 64'(1));
            chk("bp_sum", 64'(b8.sum), 64'(s));
            chk("bp_cout", 64'(b8.cout), 64'(c));
        end
        b8.out_ready = 1'b1;
        #1 chk("drain_in_ready", 64'(b8.in_ready), 64'(1));
        step();
        chk("back_idle_valid", 64'(b8.out_valid), 64'(0));
        chk("back_idle_busy", 64'(b8.busy), 64'(0));
        chk("back_idle_rdy", 64'(b8.in_ready), 64'(1));
    endtask

    initial begin
        logic [7:0] pa [3];
        logic [7:0] pb [3];
        logic       pc [3];

        b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.a = '0; b2.b = '0; b2.cin = 1'b0; b2.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0; b1.out_ready = 1'b0;

        #3;
        chk("rst_in_ready", 64'(b8.in_ready), 64'(1));
        chk("rst_out_valid", 64'(b8.out_valid), 64'(0));
        chk("rst_busy", 64'(b8.busy), 64'(0));
        chk("rst_sum", 64'(b8.sum), 64'(0));
        chk("rst_cout", 64'(b8.cout), 64'(0));
        chk("rst_w1_valid", 64'(b1.out_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run8(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run8(8'hA5, 8'h5A, 1'b1, 1'b0, 0);
        run8(8'h00, 8'h00, 1'b0, 1'b0, 0);
        run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 5);
        for (int r = 0; r < 6; r++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, r % 3);

        // Back-to-back: in_valid and out_ready high, three pairs.
        for (int i = 0; i < 3; i++) begin
            pa[i] = 8'($urandom); pb[i] = 8'($urandom); pc[i] = 1'($urandom);
        end
        b8.a = pa[0]; b8.b = pb[0]; b8.cin = pc[0];
        b8.out_ready = 1'b1;
        b8.in_valid = 1'b1;
        step();
        for (int cyc = 1; cyc <= 27; cyc++) begin
            if (cyc % 9 == 0) begin
                int idx;
                int e;
                idx = cyc / 9 - 1;
                e = int'(pa[idx]) + int'(pb[idx]) + int'(pc[idx]);
                chk("b2b_valid", 64'(b8.out_valid), 64'(1));
                chk("b2b_busy", 64'(b8.busy), 64'(0));
                chk("b2b_sum", 64'(b8.sum), 64'(e & 32'hFF));
                chk("b2b_cout", 64'(b8.cout), 64'((e >> 8) & 1));
                chk("b2b_in_ready", 64'(b8.in_ready), 64'(1));
                if (idx < 2) begin
                    b8.a = pa[idx+1]; b8.b = pb[idx+1]; b8.cin = pc[idx+1];
                end else begin
                    b8.in_valid = 1'b0;
                end
            end else begin
                chk("b2b_run_valid", 64'(b8.out_valid), 64'(0));
                chk("b2b_run_busy", 64'(b8.busy), 64'(1));
                chk("b2b_run_rdy", 64'(b8.in_ready), 64'(0));
            end
            step();
        end
        chk("b2b_end_valid", 64'(b8.out_valid), 64'(0));
        chk("b2b_end_busy", 64'(b8.busy), 64'(0));

        // Reset dropped in RUN cycle 4.
        b8.a = 8'hFF; b8.b = 8'hFF; b8.cin = 1'b1;
        b8.in_valid = 1'b1;
        step();
        b8.in_valid = 1'b0;
        repeat (3) step();
        chk("pre_rst_busy", 64'(b8.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(b8.busy), 64'(0));
        chk("mid_rst_valid", 64'(b8.out_valid), 64'(0));
        chk("mid_rst_rdy", 64'(b8.in_ready), 64'(1));
        chk("mid_rst_sum", 64'(b8.sum), 64'(0));
        chk("mid_rst_cout", 64'(b8.cout), 64'(0));
        repeat (2) begin
            step();
            chk("in_rst_valid", 64'(b8.out_valid), 64'(0));
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("post_rst_no_valid", 64'(b8.out_valid), 64'(0));
            chk("post_rst_idle", 64'(b8.busy), 64'(0));
        end
        run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 0);

        // WIDTH=2 exhaustive.
        b2.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            int e;
            b2.a = 2'(i); b2.b = 2'(i >> 2); b2.cin = 1'(i >> 4);
            e = (i & 3) + ((i >> 2) & 3) + ((i >> 4) & 1);
            b2.in_valid = 1'b1;
            step();
            b2.in_valid = 1'b0;
            for (int k = 1; k <= 2; k++) begin
                chk("w2_run_valid", 64'(b2.out_valid), 64'(0));
                step();
            end
            chk("w2_valid", 64'(b2.out_valid), 64'(1));
            chk("w2_result", 64'({b2.cout, b2.sum}), 64'(e));
            step();
        end

        // WIDTH=1 exhaustive.
        b1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int e;
            b1.a = 1'(i); b1.b = 1'(i >> 1); b1.cin = 1'(i >> 2);
            e = (i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1);
            b1.in_valid = 1'b1;
            step();
            b1.in_valid = 1'b0;
            chk("w1_run_busy", 64'(b1.busy), 64'(1));
            chk("w1_run_valid", 64'(b1.out_valid), 64'(0));
            step();
            chk("w1_valid", 64'(b1.out_valid), 64'(1));
            chk("w1_result", 64'({b1.cout, b1.sum}), 64'(e));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
